// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment table, off pattern and polarity helper for the scan controller
package seg7_pkg;

   localparam logic [7:0] SEG_OFF = 8'h00;

   // Active-high g..a patterns for hex digits 0..F
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [7:0] apply_pol(input logic [7:0] seg, input bit active_low);
      return active_low ? ~seg : seg;
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - nibble, dp and blank to an active-high 8-bit segment pattern
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   input  logic       blank,
   output logic [7:0] seg
);

   always_comb begin
      seg = blank ? SEG_OFF : {dp, HEX_SEG[nibble]};
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-seg scanner with tear-free shadow and lz blanking
// Optional blinking of masked digits is built when SEG7_BLINK_EN is defined.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int DIGITS       = 8,
   parameter int DIV          = 100000,
   parameter bit ACTIVE_LOW   = 1
`ifdef SEG7_BLINK_EN
   , parameter int BLINK_FRAMES = 32
`endif
) (
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  load,
   input  logic                  lz_en,
`ifdef SEG7_BLINK_EN
   input  logic [DIGITS-1:0]     blink_mask,
`endif
   output logic [7:0]            o_seg,
   output logic [DIGITS-1:0]     o_sel,
   output logic                  frame_done
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;
   logic [4*DIGITS-1:0]   disp_data, pend_data;
   logic [DIGITS-1:0]     disp_dp, pend_dp;
   logic                  pend;
   logic                  tick, boundary;
   logic [DIGITS-1:0]     blank;
   logic                  higher;
   logic [DIGITS-1:0]     sel_oh;
   logic                  cur_blank;
   logic [7:0]            seg_raw;

   assign tick     = (cnt == CW'(DIV - 1));
   assign boundary = tick && (idx == IW'(DIGITS - 1));
   assign sel_oh   = DIGITS'(1) << idx;

   // A digit blanks only if it and every digit above it are zero with no dp
   always_comb begin
      blank  = '0;
      higher = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         blank[i] = lz_en && higher && (disp_data[4*i +: 4] == 4'h0) && !disp_dp[i];
         higher   = blank[i];
      end
   end

`ifdef SEG7_BLINK_EN
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic [BW-1:0] blink_cnt;
   logic          blink_on;

   assign cur_blank = blank[idx] || (!blink_on && blink_mask[idx]);

   always_ff @(posedge clk_in) begin
      if (reset) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (boundary) begin
         if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
            blink_cnt <= '0;
            blink_on  <= !blink_on;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end
`else
   assign cur_blank = blank[idx];
`endif

   seg7_hex_decode u_decode (
      .nibble (disp_data[{idx, 2'b00} +: 4]),
      .dp     (disp_dp[idx]),
      .blank  (cur_blank),
      .seg    (seg_raw)
   );

   always_ff @(posedge clk_in) begin
      if (reset) begin
         cnt        <= '0;
         idx        <= '0;
         disp_data  <= '0;
         disp_dp    <= '0;
         pend_data  <= '0;
         pend_dp    <= '0;
         pend       <= 1'b0;
         frame_done <= 1'b0;
         o_seg      <= apply_pol(SEG_OFF, ACTIVE_LOW);
         o_sel      <= ACTIVE_LOW ? '1 : '0;
      end else begin
         cnt        <= tick ? '0 : cnt + 1'b1;
         if (tick)
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
         frame_done <= boundary;
         // A load landing on the boundary bypasses the pending stage
         if (boundary && load) begin
            disp_data <= data_in;
            disp_dp   <= dp_in;
            pend      <= 1'b0;
         end else if (boundary && pend) begin
            disp_data <= pend_data;
            disp_dp   <= pend_dp;
            pend      <= 1'b0;
         end else if (load) begin
            pend_data <= data_in;
            pend_dp   <= dp_in;
            pend      <= 1'b1;
         end
         o_seg <= apply_pol(seg_raw, ACTIVE_LOW);
         o_sel <= ACTIVE_LOW ? ~sel_oh : sel_oh;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - randomized and directed bench for seg7_scan_ctrl against a frame-level model
module tb_seg7_scan_ctrl;

   logic        clk_in = 1'b0;
   logic        reset;
   logic [31:0] data_in;
   logic [7:0]  dp_in;
   logic        load;
   logic        lz_en;
   logic [7:0]  blink_mask = 8'h00;
   logic [7:0]  o_seg;
   logic [7:0]  o_sel;
   logic        frame_done;

   int checks   = 0;
   int failures = 0;
   int k        = 0;

   logic [31:0] m_data, m_pdata;
   logic [7:0]  m_dp, m_pdp;
   logic        m_pend;

   logic [6:0] tbl [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   always #5 clk_in = ~clk_in;

   seg7_scan_ctrl #(
`ifdef SEG7_BLINK_EN
      .BLINK_FRAMES (2),
`endif
      .DIGITS     (8),
      .DIV        (4),
      .ACTIVE_LOW (1)
   ) dut (
`ifdef SEG7_BLINK_EN
      .blink_mask (blink_mask),
`endif
      .clk_in     (clk_in),
      .reset      (reset),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .load       (load),
      .lz_en      (lz_en),
      .o_seg      (o_seg),
      .o_sel      (o_sel),
      .frame_done (frame_done)
   );

   // Digit d is blanked when it and all digits above it show a bare zero
   function automatic logic [7:0] exp_seg(input int d);
      logic       blanked;
      logic [7:0] raw;
      blanked = lz_en && (d > 0);
      for (int j = d; j < 8; j++)
         if (m_data[4*j +: 4] != 4'h0 || m_dp[j]) blanked = 1'b0;
      raw = blanked ? 8'h00 : {m_dp[d], tbl[m_data[4*d +: 4]]};
      return ~raw;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   task automatic step(input logic ld, input logic [31:0] d, input logic [7:0] p);
      logic [7:0] e_sel, e_seg;
      logic       e_fd;
      int         dig;
      data_in = d;
      dp_in   = p;
      load    = ld;
      @(posedge clk_in);
      if (reset) begin
         k      = 0;
         m_data = '0; m_dp = '0; m_pdata = '0; m_pdp = '0; m_pend = 1'b0;
         e_sel  = 8'hFF; e_seg = 8'hFF; e_fd = 1'b0;
      end else begin
         k++;
         dig   = ((k - 1) / 4) % 8;
         e_sel = ~(8'b1 << dig);
         e_seg = exp_seg(dig);
         e_fd  = (k % 32 == 0);
         if (k % 32 == 0) begin
            if (ld) begin
               m_data = d; m_dp = p; m_pend = 1'b0;
            end else if (m_pend) begin
               m_data = m_pdata; m_dp = m_pdp; m_pend = 1'b0;
            end
         end else if (ld) begin
            m_pdata = d; m_pdp = p; m_pend = 1'b1;
         end
      end
      @(negedge clk_in);
      load = 1'b0;
      chk("o_sel", o_sel, e_sel);
      chk("o_seg", o_seg, e_seg);
      chk("frame_done", {7'b0, frame_done}, {7'b0, e_fd});
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; lz_en = 1'b0; data_in = '0; dp_in = '0;
      repeat (3) step(1'b0, 32'h0, 8'h0);
      reset = 1'b0;

      step(1'b1, 32'h12345678, 8'h00);
      repeat (70) step(1'b0, 32'h0, 8'h0);

      while (k % 32 != 12) step(1'b0, 32'h0, 8'h0);
      step(1'b1, 32'hAAAAAAAA, 8'h00);
      repeat (70) step(1'b0, 32'h0, 8'h0);

      lz_en = 1'b1;
      step(1'b1, 32'h00000F00, 8'h00);
      repeat (70) step(1'b0, 32'h0, 8'h0);
      lz_en = 1'b0;
      repeat (40) step(1'b0, 32'h0, 8'h0);

      while ((k + 1) % 32 != 0) step(1'b0, 32'h0, 8'h0);
      step(1'b1, 32'hC0FFEE42, 8'h5A);
      repeat (40) step(1'b0, 32'h0, 8'h0);

      step(1'b1, 32'h87654321, 8'h0F);
      while (k % 32 != 10) step(1'b0, 32'h0, 8'h0);
      reset = 1'b1;
      repeat (2) step(1'b0, 32'h0, 8'h0);
      reset = 1'b0;
      repeat (40) step(1'b0, 32'h0, 8'h0);

      repeat (800) begin
         if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
         if ($urandom_range(0, 3) == 0)
            step($urandom_range(0, 9) == 0, 32'($urandom) & 32'h000FF0FF, 8'($urandom) & 8'h10);
         else
            step($urandom_range(0, 9) == 0, 32'($urandom), 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
